// File: rtl/cplx_pkg.sv
// cplx_pkg: shared constants, types and helpers for the Q1.15 complex divider.
//   DW/QB       data width and number of fraction (quotient) bits
//   NQ          quotient bits produced by the serial divider (QB, or QB+1 when
//               rounding is enabled through CPLX_DIV_ROUND_EN)
//   state_t     divider FSM encoding IDLE/MULT/PREP/DIV/DONE
//   q15_pack()  turns sign, overflow flag and raw quotient into a Q1.15 word
// Optional feature macro: CPLX_DIV_ROUND_EN (round half away from zero).
package cplx_pkg;
  localparam int DW        = 16;
  localparam int QB        = DW - 1;
  localparam int PW        = 2 * DW;
  localparam int NUM_LANES = 2;          // lane 0 = real, lane 1 = imaginary
`ifdef CPLX_DIV_ROUND_EN
  localparam int NQ = QB + 1;
`else
  localparam int NQ = QB;
`endif
  localparam int CW = $clog2(NQ);

  localparam logic [DW-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [DW-1:0] Q15_MIN = 16'h8000;

  typedef enum logic [2:0] {IDLE, MULT, PREP, DIV, DONE} state_t;

  typedef struct packed {
    logic signed [DW-1:0] ar;
    logic signed [DW-1:0] aj;
    logic signed [DW-1:0] br;
    logic signed [DW-1:0] bj;
  } opnd_t;

  // q is floor(|num| * 2^NQ / den); valid only when ovf is clear.
  function automatic logic [DW-1:0] q15_pack(input logic neg, input logic ovf,
                                             input logic [NQ-1:0] q);
    logic [NQ:0]   mag;
    logic [DW-1:0] res;
`ifdef CPLX_DIV_ROUND_EN
    // extra LSB is the half bit: add it and drop it (half away from zero,
    // the sign is applied afterwards to the magnitude)
    mag = ({1'b0, q} + (NQ+1)'(1)) >> 1;
`else
    mag = {1'b0, q};
`endif
    res = mag[DW-1:0];
    if (ovf)
      return neg ? Q15_MIN : Q15_MAX;
    if (!neg && (mag > (NQ+1)'(Q15_MAX)))
      return Q15_MAX;
    // a rounded negative magnitude of 0x8000 negates onto itself: exact -1.0
    return neg ? (~res + DW'(1)) : res;
  endfunction
endpackage

// File: rtl/udiv_iter.sv
// udiv_iter: serial unsigned restoring divider, one quotient bit per step.
//   clk, rstn  clock / async active-low reset
//   start      load dividend and divisor, clear quotient
//   step       resolve one more quotient bit
//   dividend   unsigned, must be below divisor
//   divisor    unsigned, non-zero for a meaningful result
//   quotient   running quotient including the bit resolved this cycle, so the
//              final value is available on the last step edge
module udiv_iter
  import cplx_pkg::*;
#(
  parameter int QW   = NQ,
  parameter int DIVW = PW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            step,
  input  logic [DIVW-1:0] dividend,
  input  logic [DIVW-1:0] divisor,
  output logic [QW-1:0]   quotient
);
  logic [DIVW:0]   rem, sh, diff, rem_nxt;
  logic [DIVW-1:0] dvs;
  logic [QW-1:0]   q;
  logic            ge;

  // rem < dvs always holds, so the shifted remainder fits in DIVW+1 bits
  assign sh       = rem << 1;
  assign ge       = sh >= {1'b0, dvs};
  assign diff     = sh - {1'b0, dvs};
  assign rem_nxt  = ge ? diff : sh;
  assign quotient = QW'({q, ge});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem <= '0;
      dvs <= '0;
      q   <= '0;
    end else if (start) begin
      rem <= {1'b0, dividend};
      dvs <= divisor;
      q   <= '0;
    end else if (step) begin
      rem <= rem_nxt;
      q   <= quotient;
    end
  end
endmodule

// File: rtl/cplx_div.sv
// cplx_div: signed Q1.15 complex divider (a + jb) / (c + jd).
//   clk, rstn              clock / async active-low reset
//   in_valid, in_ready     operand handshake (in_ready high only when idle)
//   data1R_in, data1J_in   numerator a, b (Q1.15)
//   data2R_in, data2J_in   denominator c, d (Q1.15)
//   out_valid, out_ready   result handshake, result held until accepted
//   dataR_out, dataJ_out   quotient real / imaginary (Q1.15, saturating)
//   dz_err                 zero denominator, qualified by out_valid
// Flow: IDLE -> MULT (products) -> PREP (num/den, signs, overflow) ->
// DIV (NQ restoring steps, both lanes together) -> DONE.
// Optional feature macro: CPLX_DIV_ROUND_EN adds a rounding quotient bit.
module cplx_div
  import cplx_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data1R_in,
  input  logic [DW-1:0] data1J_in,
  input  logic [DW-1:0] data2R_in,
  input  logic [DW-1:0] data2J_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataR_out,
  output logic [DW-1:0] dataJ_out,
  output logic          dz_err
);
  state_t                              state;
  opnd_t                               op;
  logic signed [PW-1:0]                p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
  logic [NUM_LANES-1:0]                neg, ovf;
  logic                                dz;
  logic [CW-1:0]                       cnt;

  logic [NUM_LANES-1:0][PW:0]          num, mag;
  logic [PW-1:0]                       den;
  logic [NUM_LANES-1:0]                neg_c, ovf_c;
  logic [NUM_LANES-1:0][PW-1:0]        dvd;
  logic [NUM_LANES-1:0][NQ-1:0]        quot;
  logic [NUM_LANES-1:0][DW-1:0]        res;

  // Q3.30 numerators, sign-extended to 33 bits before the add/subtract
  assign num[0] = {p_ac[PW-1], p_ac} + {p_bd[PW-1], p_bd};
  assign num[1] = {p_bc[PW-1], p_bc} - {p_ad[PW-1], p_ad};
  // both squares are non-negative and at most 2^30, so the sum fits unsigned
  assign den    = $unsigned(p_cc) + $unsigned(p_dd);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign neg_c[l] = num[l][PW];
    assign mag[l]   = neg_c[l] ? (~num[l] + (PW+1)'(1)) : num[l];
    assign ovf_c[l] = mag[l] >= {1'b0, den};
    // saturating lanes feed zero so the divider never sees dividend >= divisor
    assign dvd[l]   = ovf_c[l] ? '0 : mag[l][PW-1:0];
    assign res[l]   = q15_pack(neg[l], ovf[l], quot[l]);

    udiv_iter #(.QW(NQ), .DIVW(PW)) u_div (
      .clk      (clk),
      .rstn     (rstn),
      .start    (state == PREP),
      .step     (state == DIV),
      .dividend (dvd[l]),
      .divisor  (den),
      .quotient (quot[l])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dz_err    <= 1'b0;
      dataR_out <= '0;
      dataJ_out <= '0;
      op        <= '0;
      p_ac      <= '0;
      p_bd      <= '0;
      p_bc      <= '0;
      p_ad      <= '0;
      p_cc      <= '0;
      p_dd      <= '0;
      neg       <= '0;
      ovf       <= '0;
      dz        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op       <= '{ar: data1R_in, aj: data1J_in, br: data2R_in, bj: data2J_in};
          in_ready <= 1'b0;
          state    <= MULT;
        end
        MULT: begin
          p_ac  <= PW'(op.ar) * PW'(op.br);
          p_bd  <= PW'(op.aj) * PW'(op.bj);
          p_bc  <= PW'(op.aj) * PW'(op.br);
          p_ad  <= PW'(op.ar) * PW'(op.bj);
          p_cc  <= PW'(op.br) * PW'(op.br);
          p_dd  <= PW'(op.bj) * PW'(op.bj);
          state <= PREP;
        end
        PREP: begin
          neg   <= neg_c;
          ovf   <= ovf_c;
          dz    <= (den == '0);
          cnt   <= CW'(NQ - 1);
          state <= DIV;
        end
        DIV: begin
          // the zero-denominator flag registered in PREP is acted on at the
          // first DIV cycle, abandoning the divide
          if (dz) begin
            dataR_out <= '0;
            dataJ_out <= '0;
            dz_err    <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == '0) begin
            dataR_out <= res[0];
            dataJ_out <= res[1];
            dz_err    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cplx_div.sv
// tb_cplx_div: directed vectors for cplx_div with hand-computed results.
// Honours CPLX_DIV_ROUND_EN for the expected latency and rounded result.
module tb_cplx_div;
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready, dz_err;
  logic [15:0] d1r, d1j, d2r, d2j, dataR_out, dataJ_out;

  int total = 0;
  int passed = 0;

`ifdef CPLX_DIV_ROUND_EN
  localparam int LAT = 18;
  localparam logic [15:0] R5 = 16'h2AAB;
`else
  localparam int LAT = 17;
  localparam logic [15:0] R5 = 16'h2AAA;
`endif

  always #5 clk = ~clk;

  cplx_div dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1R_in (d1r),
    .data1J_in (d1j),
    .data2R_in (d2r),
    .data2J_in (d2j),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataR_out (dataR_out),
    .dataJ_out (dataJ_out),
    .dz_err    (dz_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // present operands, return once accepted (sampled #1 after the accept edge)
  task automatic issue(input logic [15:0] a, b, c, d);
    @(negedge clk);
    d1r = a; d1j = b; d2r = c; d2j = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, b, c, d,
                        input logic [15:0] er, ej, input logic edz, input int elat);
    int lat;
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    issue(a, b, c, d);
    wait_valid(lat);
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".res"}, {31'd0, out_valid, dataR_out, dataJ_out, dz_err},
          {31'd0, 1'b1, er, ej, edz});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".ack"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int lat;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    d1r = '0; d1j = '0; d2r = '0; d2j = '0;
    #12;
    check("reset", {46'd0, in_ready, out_valid, dz_err, dataR_out, dataJ_out},
          {46'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
    @(negedge clk); rstn = 1'b1;

    run_op("t1", 16'h2000, 16'h2000, 16'h4000, 16'h0000, 16'h4000, 16'h4000, 1'b0, LAT);
    run_op("t2", 16'h0000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 1'b0, LAT);
    run_op("t3", 16'hE000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h2000, 1'b0, LAT);
    run_op("t4p", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, LAT);
    run_op("t4n", 16'hC000, 16'h0000, 16'h4000, 16'h0000, 16'h8000, 16'h0000, 1'b0, LAT);
    run_op("t5", 16'h1000, 16'h0000, 16'h3000, 16'h0000, R5, 16'h0000, 1'b0, LAT);
    run_op("t6dz", 16'h1234, 16'h4321, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3);
    run_op("t6ok", 16'h2000, 16'h2000, 16'h4000, 16'h0000, 16'h4000, 16'h4000, 1'b0, LAT);

    // back-pressure: result held, new operands ignored while busy
    issue(16'h0000, 16'h2000, 16'h0000, 16'h4000);
    wait_valid(lat);
    check("bp.lat", 64'(lat), 64'(LAT));
    @(negedge clk);
    in_valid = 1'b1; d1r = 16'h4000; d1j = 16'h4000; d2r = 16'h4000; d2j = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d", i),
            {30'd0, out_valid, in_ready, dataR_out, dataJ_out},
            {30'd0, 1'b1, 1'b0, 16'h4000, 16'h0000});
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp.ack", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    #20;
    check("bp.idle", 64'(out_valid), 64'd0);

    // reset in the middle of a divide
    issue(16'h2000, 16'h2000, 16'h4000, 16'h0000);
    repeat (8) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("rst.mid", {46'd0, in_ready, out_valid, dz_err, dataR_out, dataJ_out},
          {46'd0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0});
    @(negedge clk); rstn = 1'b1;
    #1;
    check("rst.rel", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    run_op("t7", 16'hE000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h2000, 1'b0, LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
